// File: rtl/prio_req_encoder_pkg.sv
// Shared constants for the request encoder: request/code widths and FSM state encodings.
package prio_req_encoder_pkg;

    localparam int N_REQ  = 4;
    localparam int CODE_W = 2;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_GRANT   = 2'b01;
    localparam logic [1:0] ST_RELEASE = 2'b10;

endpackage

// File: rtl/prio_req_encoder_prio_enc4.sv
// Combinational 4->2 fixed-priority encoder; the highest set request bit wins.
module prio_enc4
    import prio_req_encoder_pkg::*;
(
    input  logic [N_REQ-1:0]  req_i,
    output logic [CODE_W-1:0] code_o,
    output logic              any_o
);

    always_comb begin
        code_o = '0;
        // Ascending scan so a later, higher index overrides a lower one.
        for (int i = 0; i < N_REQ; i++) begin
            if (req_i[i]) begin
                code_o = CODE_W'(i);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/prio_req_encoder.sv
// Arbitrates four request lines and holds the winning 2-bit code for the downstream
// decoder until the requester finishes, drops its request, or the hold watchdog fires.
module prio_req_encoder
    import prio_req_encoder_pkg::*;
#(
    parameter int HOLD_MAX = 15
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic             a,
    output logic             b,
    output logic             valid,
    output logic             busy,
    output logic             timeout
);

    localparam int                CNT_W    = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(HOLD_MAX);

    logic [1:0]        state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_q, timeout_d;

    logic [CODE_W-1:0] enc_code;
    logic              enc_any;

    prio_enc4 u_enc (
        .req_i  (req),
        .code_o (enc_code),
        .any_o  (enc_any)
    );

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (enc_any) begin
                    code_d  = enc_code;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // A normal finish beats watchdog expiry in the same cycle.
                if (done || !req[code_q]) begin
                    state_d = ST_RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_RELEASE;
                    timeout_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            code_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Status outputs decode registered state only, so no input reaches an output combinationally.
    assign a       = code_q[1];
    assign b       = code_q[0];
    assign valid   = (state_q == ST_GRANT);
    assign busy    = (state_q == ST_GRANT) || (state_q == ST_RELEASE);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_prio_req_encoder.sv
// Directed scenarios followed by random traffic, each cycle checked against a behavioural model.
module tb_prio_req_encoder;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic       a, b, valid, busy, timeout;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase flags and age of the current grant in GRANT cycles.
    logic       m_grant = 1'b0;
    logic       m_rel   = 1'b0;
    logic [1:0] m_code  = 2'b00;
    logic       m_to    = 1'b0;
    int         m_age   = 0;

    prio_req_encoder #(.HOLD_MAX(HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .a       (a),
        .b       (b),
        .valid   (valid),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] highest(input logic [3:0] r);
        logic [1:0] p;
        p = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (r[i]) p = 2'(i);
        end
        return p;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle(input logic r_rst, input logic [3:0] r_req, input logic r_done);
        rst  = r_rst;
        req  = r_req;
        done = r_done;
        @(posedge clk);
        if (r_rst) begin
            m_grant = 1'b0; m_rel = 1'b0; m_code = 2'b00; m_to = 1'b0; m_age = 0;
        end else if (m_rel) begin
            m_rel = 1'b0; m_to = 1'b0;
        end else if (m_grant) begin
            m_age++;
            m_to = 1'b0;
            if (r_done || !r_req[m_code]) begin
                m_grant = 1'b0; m_rel = 1'b1;
            end else if (m_age == HOLD) begin
                m_grant = 1'b0; m_rel = 1'b1; m_to = 1'b1;
            end
        end else begin
            m_to = 1'b0;
            if (r_req != 4'b0000) begin
                m_code = highest(r_req); m_grant = 1'b1; m_age = 0;
            end
        end
        #1;
        chk("code",    {2'b00, a, b},  {2'b00, m_code});
        chk("valid",   {3'b000, valid}, {3'b000, m_grant});
        chk("busy",    {3'b000, busy},  {3'b000, m_grant | m_rel});
        chk("timeout", {3'b000, timeout}, {3'b000, m_to});
        $display("t=%0t rst=%b req=%b done=%b -> a=%b b=%b valid=%b busy=%b timeout=%b",
                 $time, r_rst, r_req, r_done, a, b, valid, busy, timeout);
    endtask

    initial begin
        // Reset held two cycles with all requests asserted.
        cycle(1'b1, 4'b1111, 1'b0);
        cycle(1'b1, 4'b1111, 1'b0);
        chk("rst_quiet", {a, b, valid, busy}, 4'b0000);
        cycle(1'b0, 4'b0000, 1'b0);

        // Grant to req[2], done after three grant cycles.
        cycle(1'b0, 4'b0110, 1'b0);
        chk("sc1_grant", {a, b, valid, busy}, 4'b1011);
        cycle(1'b0, 4'b0110, 1'b0);
        cycle(1'b0, 4'b0110, 1'b0);
        cycle(1'b0, 4'b0110, 1'b1);
        chk("sc1_release", {a, b, valid, busy}, 4'b1001);
        cycle(1'b0, 4'b0000, 1'b0);
        chk("sc1_idle", {2'b00, valid, busy}, 4'b0000);

        // No preemption: req[0] keeps the grant while req[3] waits.
        cycle(1'b0, 4'b0001, 1'b0);
        cycle(1'b0, 4'b1001, 1'b0);
        cycle(1'b0, 4'b1001, 1'b0);
        chk("sc2_nopreempt", {a, b, valid, timeout}, 4'b0010);
        cycle(1'b0, 4'b1001, 1'b1);
        cycle(1'b0, 4'b1001, 1'b0);
        cycle(1'b0, 4'b1001, 1'b0);
        chk("sc2_winner", {a, b, valid, busy}, 4'b1111);
        cycle(1'b0, 4'b0000, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0);

        // Watchdog: req[2] held without done for HOLD grant cycles.
        cycle(1'b0, 4'b0100, 1'b0);
        for (int i = 0; i < HOLD - 1; i++) cycle(1'b0, 4'b0100, 1'b0);
        chk("sc3_pre_expiry", {2'b00, valid, timeout}, 4'b0010);
        cycle(1'b0, 4'b0100, 1'b0);
        chk("sc3_timeout", {2'b00, valid, timeout}, 4'b0001);
        cycle(1'b0, 4'b0000, 1'b0);
        chk("sc3_pulse_end", {3'b000, timeout}, 4'b0000);
        cycle(1'b0, 4'b0000, 1'b0);

        // done on the expiry cycle suppresses the pulse.
        cycle(1'b0, 4'b0100, 1'b0);
        for (int i = 0; i < HOLD - 1; i++) cycle(1'b0, 4'b0100, 1'b0);
        cycle(1'b0, 4'b0100, 1'b1);
        chk("sc4_done_wins", {2'b00, valid, timeout}, 4'b0000);
        cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0);

        // Dropping the granted request releases without a timeout.
        cycle(1'b0, 4'b0100, 1'b0);
        cycle(1'b0, 4'b0100, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0);
        chk("sc4_drop", {2'b00, valid, timeout}, 4'b0000);
        cycle(1'b0, 4'b0000, 1'b0);

        // Reset in the middle of a grant.
        cycle(1'b0, 4'b1000, 1'b0);
        cycle(1'b0, 4'b1000, 1'b0);
        cycle(1'b1, 4'b1000, 1'b0);
        chk("sc5_rst_grant", {a, b, valid, busy}, 4'b0000);
        cycle(1'b0, 4'b0000, 1'b0);

        // Random traffic; requests mostly held so grants can also run to expiry.
        for (int n = 0; n < 400; n++) begin
            logic [3:0] r_req;
            r_req = req;
            if ($urandom_range(0, 3) == 0) r_req = 4'($urandom_range(0, 15));
            cycle($urandom_range(0, 99) == 0, r_req, $urandom_range(0, 9) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
